// File: rtl/pipe_flag_pkg.sv
// Shared defaults and stage-index names for the pipeline flag tracker.
package pipe_flag_pkg;

  localparam int NUM_STAGES_DEF = 5;
  localparam int NUM_FLAGS_DEF  = 4;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [3:0] {
    STG_IF  = 4'd0,
    STG_ID  = 4'd1,
    STG_EX  = 4'd2,
    STG_MEM = 4'd3,
    STG_WB  = 4'd4
  } stage_idx_e;

endpackage

// File: rtl/pipe_flag_stage.sv
// One pipeline stage register holding a valid bit plus its flags.
// Priority is flush, then hold, then load.
module pipe_flag_stage
  import pipe_flag_pkg::*;
#(
  parameter int NUM_FLAGS = NUM_FLAGS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  input  logic                 i_hold,
  input  logic                 i_valid,
  input  logic [NUM_FLAGS-1:0] i_flags,
  output logic                 o_valid,
  output logic [NUM_FLAGS-1:0] o_flags
);

  logic                 r_valid;
  logic [NUM_FLAGS-1:0] r_flags;

  // Flags are gated by valid on load so an empty stage never carries flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_flags <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_flags <= '0;
    end else if (!i_hold) begin
      r_valid <= i_valid;
      r_flags <= i_valid ? i_flags : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_flags = r_flags;

endmodule

// File: rtl/pipe_flag_tracker.sv
// Tracks per-instruction flag bits down an in-order pipeline and keeps
// per-channel sticky bits and saturating counters of flagged retirements.
module pipe_flag_tracker
  import pipe_flag_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int NUM_FLAGS  = NUM_FLAGS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [NUM_FLAGS-1:0]            flag_in,
  input  logic [NUM_STAGES-1:0]           stall,
  input  logic [NUM_STAGES-1:0]           flush,
  input  logic [NUM_FLAGS-1:0]            sticky_clr,
  output logic [NUM_STAGES-1:0]           valid_stage,
  output logic [NUM_STAGES*NUM_FLAGS-1:0] flag_stage,
  output logic [NUM_STAGES-1:0]           flag_any,
  output logic [NUM_FLAGS-1:0]            sticky,
  output logic [NUM_FLAGS*CNT_W-1:0]      retire_cnt
);

  localparam int LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] w_hold;
  logic [NUM_STAGES-1:0] w_valid;
  logic [NUM_STAGES-1:0] w_in_valid;
  logic [NUM_FLAGS-1:0]  w_flags    [NUM_STAGES];
  logic [NUM_FLAGS-1:0]  w_in_flags [NUM_STAGES];
  logic                  w_retire;
  logic [NUM_FLAGS-1:0]  w_ret_flags;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      // A stall anywhere downstream freezes this stage too.
      assign w_hold[gi] = |(stall >> gi);

      if (gi == int'(STG_IF)) begin : g_first
        assign w_in_valid[gi] = valid_in;
        assign w_in_flags[gi] = flag_in & {NUM_FLAGS{valid_in}};
      end else begin : g_rest
        assign w_in_valid[gi] = w_hold[gi-1] ? 1'b0 : w_valid[gi-1];
        assign w_in_flags[gi] = w_hold[gi-1] ? '0 : w_flags[gi-1];
      end

      pipe_flag_stage #(
        .NUM_FLAGS (NUM_FLAGS)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush[gi]),
        .i_hold  (w_hold[gi]),
        .i_valid (w_in_valid[gi]),
        .i_flags (w_in_flags[gi]),
        .o_valid (w_valid[gi]),
        .o_flags (w_flags[gi])
      );

      assign valid_stage[gi]                          = w_valid[gi];
      assign flag_stage[gi*NUM_FLAGS +: NUM_FLAGS]    = w_flags[gi];
      assign flag_any[gi]                             = w_valid[gi] & (|w_flags[gi]);
    end
  endgenerate

  assign w_retire    = w_valid[LAST] & ~stall[LAST] & ~flush[LAST];
  assign w_ret_flags = w_flags[LAST] & {NUM_FLAGS{w_retire}};

  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_chan
      logic             r_sticky;
      logic [CNT_W-1:0] r_cnt;

      // A clear coincident with a retire counts that retire as the first one.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sticky <= 1'b0;
          r_cnt    <= '0;
        end else if (sticky_clr[gi]) begin
          r_sticky <= w_ret_flags[gi];
          r_cnt    <= w_ret_flags[gi] ? CNT_W'(1) : '0;
        end else if (w_ret_flags[gi]) begin
          r_sticky <= 1'b1;
          if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign sticky[gi]                     = r_sticky;
      assign retire_cnt[gi*CNT_W +: CNT_W]  = r_cnt;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_flag_tracker.sv
// Directed self-checking bench for pipe_flag_tracker (5 stages, 4 flags, 8-bit counters).
module tb_pipe_flag_tracker;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [3:0]  flag_in;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic [3:0]  sticky_clr;
  logic [4:0]  valid_stage;
  logic [19:0] flag_stage;
  logic [4:0]  flag_any;
  logic [3:0]  sticky;
  logic [31:0] retire_cnt;

  int checks;
  int errors;

  pipe_flag_tracker #(
    .NUM_STAGES (5),
    .NUM_FLAGS  (4),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .flag_in     (flag_in),
    .stall       (stall),
    .flush       (flush),
    .sticky_clr  (sticky_clr),
    .valid_stage (valid_stage),
    .flag_stage  (flag_stage),
    .flag_any    (flag_any),
    .sticky      (sticky),
    .retire_cnt  (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0; flag_in = 4'h0; stall = 5'h0; flush = 5'h0; sticky_clr = 4'h0;
    #1 reset = 1'b0;
    #1;
    checks++; if (valid_stage !== 5'h0) begin errors++; $display("FAIL reset_valid got %h exp %h", valid_stage, 5'h0); end
    checks++; if (flag_stage !== 20'h0) begin errors++; $display("FAIL reset_flags got %h exp %h", flag_stage, 20'h0); end
    checks++; if (flag_any !== 5'h0) begin errors++; $display("FAIL reset_any got %h exp %h", flag_any, 5'h0); end
    checks++; if (sticky !== 4'h0) begin errors++; $display("FAIL reset_sticky got %h exp %h", sticky, 4'h0); end
    checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp %h", retire_cnt, 32'h0); end
    @(posedge clk);
    #3 reset = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_single();
    logic [19:0] exp_f;
    logic [4:0]  exp_v;
    valid_in = 1'b1; flag_in = 4'b0101;
    step();
    valid_in = 1'b0; flag_in = 4'h0;
    for (int i = 0; i < 5; i++) begin
      exp_f = 20'h5 << (4 * i);
      exp_v = 5'h1 << i;
      checks++; if (flag_stage !== exp_f) begin errors++; $display("FAIL single_flags_s%0d got %h exp %h", i, flag_stage, exp_f); end
      checks++; if (valid_stage !== exp_v) begin errors++; $display("FAIL single_valid_s%0d got %h exp %h", i, valid_stage, exp_v); end
      checks++; if (flag_any !== exp_v) begin errors++; $display("FAIL single_any_s%0d got %h exp %h", i, flag_any, exp_v); end
      checks++; if (sticky !== 4'h0) begin errors++; $display("FAIL single_early_sticky_s%0d got %h exp %h", i, sticky, 4'h0); end
      $display("single: stage %0d flag_stage=%h", i, flag_stage);
      step();
    end
    checks++; if (sticky !== 4'b0101) begin errors++; $display("FAIL single_sticky got %h exp %h", sticky, 4'b0101); end
    checks++; if (retire_cnt !== 32'h00010001) begin errors++; $display("FAIL single_cnt got %h exp %h", retire_cnt, 32'h00010001); end
    checks++; if (valid_stage !== 5'h0) begin errors++; $display("FAIL single_drained got %h exp %h", valid_stage, 5'h0); end
    sticky_clr = 4'hF;
    step();
    sticky_clr = 4'h0;
    checks++; if (sticky !== 4'h0) begin errors++; $display("FAIL single_clr_sticky got %h exp %h", sticky, 4'h0); end
    checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL single_clr_cnt got %h exp %h", retire_cnt, 32'h0); end
    $display("single: retired sticky=%h", sticky);
  endtask

  task automatic test_bubble_flags();
    valid_in = 1'b0; flag_in = 4'hF;
    step();
    flag_in = 4'h0;
    checks++; if (flag_stage !== 20'h0) begin errors++; $display("FAIL bubble_flags got %h exp %h", flag_stage, 20'h0); end
    checks++; if (flag_any !== 5'h0) begin errors++; $display("FAIL bubble_any got %h exp %h", flag_any, 5'h0); end
    $display("bubble: flag_stage=%h", flag_stage);
  endtask

  task automatic test_stall();
    valid_in = 1'b1; flag_in = 4'b0001; step();
    flag_in = 4'b0010; step();
    flag_in = 4'b0100; step();
    valid_in = 1'b0; flag_in = 4'h0; stall = 5'b00100;
    checks++; if (flag_stage !== 20'h00124) begin errors++; $display("FAIL stall_load got %h exp %h", flag_stage, 20'h00124); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (flag_stage !== 20'h00124) begin errors++; $display("FAIL stall_frozen_c%0d got %h exp %h", c, flag_stage, 20'h00124); end
      checks++; if (valid_stage !== 5'b00111) begin errors++; $display("FAIL stall_valid_c%0d got %h exp %h", c, valid_stage, 5'b00111); end
      $display("stall: cycle %0d flag_stage=%h", c, flag_stage);
    end
    stall = 5'h0;
    step();
    checks++; if (flag_stage !== 20'h01240) begin errors++; $display("FAIL stall_rel1 got %h exp %h", flag_stage, 20'h01240); end
    checks++; if (valid_stage !== 5'b01110) begin errors++; $display("FAIL stall_rel1_valid got %h exp %h", valid_stage, 5'b01110); end
    step();
    checks++; if (flag_stage !== 20'h12400) begin errors++; $display("FAIL stall_rel2 got %h exp %h", flag_stage, 20'h12400); end
    step();
    checks++; if (sticky !== 4'b0001) begin errors++; $display("FAIL stall_retA got %h exp %h", sticky, 4'b0001); end
    checks++; if (flag_stage !== 20'h24000) begin errors++; $display("FAIL stall_retA_flags got %h exp %h", flag_stage, 20'h24000); end
    step();
    checks++; if (sticky !== 4'b0011) begin errors++; $display("FAIL stall_retB got %h exp %h", sticky, 4'b0011); end
    step();
    checks++; if (sticky !== 4'b0111) begin errors++; $display("FAIL stall_retC got %h exp %h", sticky, 4'b0111); end
    checks++; if (retire_cnt !== 32'h00010101) begin errors++; $display("FAIL stall_cnt got %h exp %h", retire_cnt, 32'h00010101); end
    $display("stall: order retired sticky=%h cnt=%h", sticky, retire_cnt);
    sticky_clr = 4'hF; step(); sticky_clr = 4'h0;
  endtask

  task automatic test_flush();
    valid_in = 1'b1; flag_in = 4'b1000; step();
    valid_in = 1'b0; flag_in = 4'h0;
    step(); step(); step();
    checks++; if (flag_stage !== 20'h08000) begin errors++; $display("FAIL flush_pre got %h exp %h", flag_stage, 20'h08000); end
    stall = 5'b01000; flush = 5'b01000;
    step();
    stall = 5'h0; flush = 5'h0;
    checks++; if (valid_stage !== 5'h0) begin errors++; $display("FAIL flush_valid got %h exp %h", valid_stage, 5'h0); end
    checks++; if (flag_stage !== 20'h0) begin errors++; $display("FAIL flush_flags got %h exp %h", flag_stage, 20'h0); end
    step(); step(); step();
    checks++; if (sticky !== 4'h0) begin errors++; $display("FAIL flush_sticky got %h exp %h", sticky, 4'h0); end
    checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL flush_cnt got %h exp %h", retire_cnt, 32'h0); end
    $display("flush: no retire sticky=%h", sticky);
    // A stalled WB must not retire until released.
    valid_in = 1'b1; flag_in = 4'b0100; step();
    valid_in = 1'b0; flag_in = 4'h0;
    step(); step(); step(); step();
    checks++; if (valid_stage !== 5'b10000) begin errors++; $display("FAIL wbstall_pre got %h exp %h", valid_stage, 5'b10000); end
    stall = 5'b10000;
    step(); step();
    checks++; if (sticky !== 4'h0) begin errors++; $display("FAIL wbstall_sticky got %h exp %h", sticky, 4'h0); end
    checks++; if (valid_stage !== 5'b10000) begin errors++; $display("FAIL wbstall_held got %h exp %h", valid_stage, 5'b10000); end
    stall = 5'h0;
    step();
    checks++; if (retire_cnt !== 32'h00010000) begin errors++; $display("FAIL wbstall_cnt got %h exp %h", retire_cnt, 32'h00010000); end
    $display("wbstall: released cnt=%h", retire_cnt);
    sticky_clr = 4'hF; step(); sticky_clr = 4'h0;
  endtask

  task automatic test_back_to_back_saturate();
    valid_in = 1'b1; flag_in = 4'b1000;
    for (int m = 1; m <= 300; m++) begin
      step();
      if (m == 259) begin
        checks++; if (retire_cnt !== 32'hFE000000) begin errors++; $display("FAIL sat_254 got %h exp %h", retire_cnt, 32'hFE000000); end
        $display("b2b: m=%0d cnt=%h", m, retire_cnt);
      end
      if (m == 260) begin
        checks++; if (retire_cnt !== 32'hFF000000) begin errors++; $display("FAIL sat_255 got %h exp %h", retire_cnt, 32'hFF000000); end
        $display("b2b: m=%0d cnt=%h", m, retire_cnt);
      end
    end
    checks++; if (retire_cnt !== 32'hFF000000) begin errors++; $display("FAIL sat_held got %h exp %h", retire_cnt, 32'hFF000000); end
    checks++; if (sticky !== 4'b1000) begin errors++; $display("FAIL sat_sticky got %h exp %h", sticky, 4'b1000); end
    $display("b2b: m=300 cnt=%h", retire_cnt);
    sticky_clr = 4'b1000;
    step();
    sticky_clr = 4'h0;
    checks++; if (retire_cnt !== 32'h01000000) begin errors++; $display("FAIL clr_retire_cnt got %h exp %h", retire_cnt, 32'h01000000); end
    checks++; if (sticky !== 4'b1000) begin errors++; $display("FAIL clr_retire_sticky got %h exp %h", sticky, 4'b1000); end
    step();
    checks++; if (retire_cnt !== 32'h02000000) begin errors++; $display("FAIL clr_then_inc got %h exp %h", retire_cnt, 32'h02000000); end
    $display("b2b: clear with retire cnt=%h", retire_cnt);
  endtask

  task automatic test_async_reset();
    checks++; if (valid_stage !== 5'h1F) begin errors++; $display("FAIL areset_full got %h exp %h", valid_stage, 5'h1F); end
    #2 reset = 1'b0;
    #1;
    checks++; if (valid_stage !== 5'h0) begin errors++; $display("FAIL areset_valid got %h exp %h", valid_stage, 5'h0); end
    checks++; if (flag_stage !== 20'h0) begin errors++; $display("FAIL areset_flags got %h exp %h", flag_stage, 20'h0); end
    checks++; if (flag_any !== 5'h0) begin errors++; $display("FAIL areset_any got %h exp %h", flag_any, 5'h0); end
    checks++; if (sticky !== 4'h0) begin errors++; $display("FAIL areset_sticky got %h exp %h", sticky, 4'h0); end
    checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL areset_cnt got %h exp %h", retire_cnt, 32'h0); end
    $display("areset: outputs cleared mid-cycle");
    valid_in = 1'b0; flag_in = 4'h0;
    @(posedge clk);
    #3 reset = 1'b1;
    valid_in = 1'b1; flag_in = 4'b0010;
    step();
    valid_in = 1'b0; flag_in = 4'h0;
    checks++; if (flag_stage !== 20'h00002) begin errors++; $display("FAIL areset_enter got %h exp %h", flag_stage, 20'h00002); end
    step(); step(); step(); step(); step();
    checks++; if (sticky !== 4'b0010) begin errors++; $display("FAIL areset_sticky_after got %h exp %h", sticky, 4'b0010); end
    checks++; if (retire_cnt !== 32'h00000100) begin errors++; $display("FAIL areset_cnt_after got %h exp %h", retire_cnt, 32'h00000100); end
    $display("areset: new instruction retired cnt=%h", retire_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_bubble_flags();
    test_stall();
    test_flush();
    test_back_to_back_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_flag_tracker.md
PIPE_FLAG_TRACKER -- requirements
Module: pipe_flag_tracker

Interface
REQ-001 Parameter NUM_STAGES, default 5, pipeline stages tracked; stage 0 is IF, stage NUM_STAGES-1 is WB; legal range 2..16.
REQ-002 Parameter NUM_FLAGS, default 4, independent flag channels per instruction; legal range 1..32.
REQ-003 Parameter CNT_W, default 8, width of each per-channel retire counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  an instruction enters stage 0 this cycle.
REQ-007 flag_in  input  NUM_FLAGS  flags raised by the entering instruction; ignored when valid_in=0.
REQ-008 stall  input  NUM_STAGES  stall[i]=1 requests that stage i hold.
REQ-009 flush  input  NUM_STAGES  flush[i]=1 kills the occupant of stage i.
REQ-010 sticky_clr  input  NUM_FLAGS  per-channel clear of sticky bit and retire counter.
REQ-011 valid_stage  output  NUM_STAGES  stage i holds a live instruction.
REQ-012 flag_stage  output  NUM_STAGES*NUM_FLAGS  flags of stage i at bits [i*NUM_FLAGS +: NUM_FLAGS].
REQ-013 flag_any  output  NUM_STAGES  OR of stage i's flags, gated by valid_stage[i].
REQ-014 sticky  output  NUM_FLAGS  channel f has retired at least one flagged instruction since the last clear.
REQ-015 retire_cnt  output  NUM_FLAGS*CNT_W  per-channel count of flagged retirements, channel f at [f*CNT_W +: CNT_W].

Function
REQ-016 Effective hold h[i] SHALL be the OR of stall[j] for j>=i; a downstream stall freezes all upstream stages.
REQ-017 Per-stage priority SHALL be: flush[i] (valid=0, flags=0), then h[i] (hold), then advance.
REQ-018 On advance, stage 0 SHALL load valid_in and (flag_in AND valid_in).
REQ-019 On advance, stage i>0 SHALL load stage i-1 if h[i-1]=0, else load a bubble (valid=0, flags=0).
REQ-020 A bubble or flushed stage SHALL always carry all-zero flags; invalid stages never report flags.
REQ-021 A retire event SHALL occur in a cycle where stage NUM_STAGES-1 is valid, stall[NUM_STAGES-1]=0 and flush[NUM_STAGES-1]=0.
REQ-022 On a retire event, each channel f with its flag set SHALL set sticky[f] and increment retire_cnt[f] by 1 on the next edge.
REQ-023 retire_cnt[f] SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-024 sticky_clr[f] SHALL zero sticky[f] and retire_cnt[f]; a simultaneous retire on f SHALL leave sticky[f]=1 and retire_cnt[f]=1.
REQ-025 All outputs SHALL be registered or direct decodes of registers, with no combinational path from any input.
REQ-026 Latency: a flag entering at edge k SHALL appear in stage i after edge k+i when no holds or flushes occur; it retires NUM_STAGES cycles after entry.

Reset
REQ-027 While reset=0, valid_stage, flag_stage, flag_any, sticky and retire_cnt SHALL all be zero, asynchronously.
REQ-028 Reset asserted mid-flight SHALL discard all in-flight flags; the first edge after release SHALL process inputs normally.

Structure
REQ-029 Default parameter constants and the stage-index names (STG_IF=0 ... STG_WB=4) SHALL live in shared package pipe_flag_pkg.
REQ-030 One stage register (valid plus flags, with flush, hold and load muxing) SHALL be sub-module pipe_flag_stage, instantiated NUM_STAGES times by a generate loop.
REQ-031 Sticky and counter logic SHALL remain in the top level.

Verification (NUM_STAGES=5, NUM_FLAGS=4, CNT_W=8)
REQ-032 Single valid_in with flag_in=4'b0101 and no stalls -> stages 0..4 show 0101 on consecutive cycles; sticky=0101 and retire_cnt[0]=retire_cnt[2]=1 one edge after the WB cycle.
REQ-033 stall[2] held 3 cycles with instructions A(0001), B(0010), C(0100) in stages 2/1/0 -> stages 0..2 frozen; stage 3 shows bubbles; order A,B,C preserved after release.
REQ-034 flush[3] coincident with stall[3] on a flagged instruction -> stage 3 cleared next edge and no retire occurs for it.
REQ-035 300 back-to-back retirements with flag 1000 -> retire_cnt[3]=255 held; sticky_clr[3] coincident with a retire -> retire_cnt[3]=1, sticky[3]=1.
REQ-036 reset driven low asynchronously mid-cycle with all stages full -> all outputs 0 before the next edge; after release, a new instruction tracks normally.
